cfg_chain_feedthrough: RTL and testbench

Parametrised successor to the CLB tile feedthrough. It carries NUM_CHAINS configuration-chain heads from the north edge to the south edge through PIPE_DEPTH retiming stages that advance only while configuration is enabled. It also retimes the E/W reset and test-enable fan-out. A frame-tracking FSM counts shifted bits per frame and flags complete, short and overrun frames for bring-up debug. It sits in every CLB tile column on the programming clock domain.

---
 rtl/cfg_chain_feedthrough.sv | 204 ++++++++++++++++++++
 tb/tb_cfg_chain_feedthrough.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_feedthrough.sv
// Configuration-chain feedthrough for one CLB tile column.
//
// Carries NUM_CHAINS configuration-chain heads from the north edge to the south edge
// through PIPE_DEPTH retiming stages. The stages advance only while the registered
// configuration enable is high. The block also forwards the fabric reset and test
// enable across the tile in the E<->W direction. A small FSM counts the shifts in
// each frame and flags complete, short and overrun frames for bring-up debug.
//
// Ports:
//   prog_clk            programming clock (sole clock)
//   pReset_N            synchronous active-low reset
//   config_enable_N_in  configuration enable from the north neighbour
//   config_enable       registered local configuration enable
//   sc_head_N_in        chain heads from the north
//   sc_head_S_out       retimed chain heads to the south
//   reset_E_in/W_in     fabric reset from the east/west
//   reset_W_out/E_out   reset forwarded to the west/east
//   Test_en_E_in/W_in   test enable from the east/west
//   Test_en_W_out/E_out test enable forwarded to the west/east
//   bit_count           shifts counted in the current frame
//   frame_done          last frame completed with exactly FRAME_LEN shifts
//   frame_err           sticky short/overrun frame flag
module cfg_chain_feedthrough #(
   parameter int unsigned NUM_CHAINS  = 1,
   parameter int unsigned PIPE_DEPTH  = 2,
   parameter int unsigned FRAME_LEN   = 64,
   parameter int unsigned CNT_W       = $clog2(FRAME_LEN + 1),
   parameter bit          RETIME_CTRL = 1'b1
) (
   input  logic                  prog_clk,
   input  logic                  pReset_N,
   input  logic                  config_enable_N_in,
   output logic                  config_enable,
   input  logic [NUM_CHAINS-1:0] sc_head_N_in,
   output logic [NUM_CHAINS-1:0] sc_head_S_out,
   input  logic                  reset_E_in,
   input  logic                  reset_W_in,
   output logic                  reset_W_out,
   output logic                  reset_E_out,
   input  logic                  Test_en_E_in,
   input  logic                  Test_en_W_in,
   output logic                  Test_en_W_out,
   output logic                  Test_en_E_out,
   output logic [CNT_W-1:0]      bit_count,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam logic [CNT_W-1:0] FrameLenC = CNT_W'(FRAME_LEN);

   typedef enum logic [1:0] {StIdle, StShift, StDone, StOverrun} state_e;

   // Local enable; every edge with en_q high is a shift edge.
   logic en_q;

   always_ff @(posedge prog_clk) begin
      if (!pReset_N) begin
         en_q <= 1'b0;
      end else begin
         en_q <= config_enable_N_in;
      end
   end

   assign config_enable = en_q;

   // Chain retiming pipe
   if (PIPE_DEPTH == 0) begin : g_pipe_bypass
      assign sc_head_S_out = sc_head_N_in;
   end else begin : g_pipe
      logic [NUM_CHAINS-1:0] pipe_q [PIPE_DEPTH];

      always_ff @(posedge prog_clk) begin
         if (!pReset_N) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
               pipe_q[i] <= '0;
            end
         end else if (en_q) begin
            pipe_q[0] <= sc_head_N_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end
      end

      assign sc_head_S_out = pipe_q[PIPE_DEPTH-1];
   end

   // E/W control forwarding; runs regardless of the configuration enable.
   if (RETIME_CTRL) begin : g_ctrl_reg
      logic reset_w_q, reset_e_q, test_en_w_q, test_en_e_q;

      always_ff @(posedge prog_clk) begin
         if (!pReset_N) begin
            reset_w_q   <= 1'b0;
            reset_e_q   <= 1'b0;
            test_en_w_q <= 1'b0;
            test_en_e_q <= 1'b0;
         end else begin
            reset_w_q   <= reset_E_in;
            reset_e_q   <= reset_W_in;
            test_en_w_q <= Test_en_E_in;
            test_en_e_q <= Test_en_W_in;
         end
      end

      assign reset_W_out   = reset_w_q;
      assign reset_E_out   = reset_e_q;
      assign Test_en_W_out = test_en_w_q;
      assign Test_en_E_out = test_en_e_q;
   end else begin : g_ctrl_comb
      assign reset_W_out   = reset_E_in;
      assign reset_E_out   = reset_W_in;
      assign Test_en_W_out = Test_en_E_in;
      assign Test_en_E_out = Test_en_W_in;
   end

   // Frame-tracking FSM
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_inc;

   // Cannot wrap: cnt_q < FRAME_LEN whenever the increment is used.
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (en_q) begin
               cnt_d  = CNT_W'(1);
               done_d = 1'b0;
               if (FRAME_LEN == 1) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StShift;
               end
            end else begin
               cnt_d = '0;
            end
         end
         StShift: begin
            if (en_q) begin
               cnt_d = cnt_inc;
               if (cnt_inc == FrameLenC) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end else begin
               // Enable dropped before the frame filled: short frame.
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         StDone: begin
            if (en_q) begin
               err_d   = 1'b1;
               cnt_d   = FrameLenC;
               state_d = StOverrun;
            end else begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         StOverrun: begin
            if (en_q) begin
               cnt_d = FrameLenC;
            end else begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (!pReset_N) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bit_count  = cnt_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_cfg_chain_feedthrough.sv
module tb_cfg_chain_feedthrough;

   localparam int unsigned NC  = 2;
   localparam int unsigned FL  = 4;
   localparam int unsigned CW  = $clog2(FL + 1);

   logic          prog_clk = 1'b0;
   logic          pReset_N;
   logic          en_in;
   logic [NC-1:0] sc_in;
   logic          rst_e_in, rst_w_in, te_e_in, te_w_in;

   // Registered instance (PIPE_DEPTH=2, RETIME_CTRL=1)
   logic          cfg_en;
   logic [NC-1:0] sc_out;
   logic          rst_w_out, rst_e_out, te_w_out, te_e_out;
   logic [CW-1:0] bit_count;
   logic          frame_done, frame_err;

   // Combinational instance (PIPE_DEPTH=0, RETIME_CTRL=0)
   logic          c_cfg_en;
   logic [NC-1:0] c_sc_out;
   logic          c_rst_w_out, c_rst_e_out, c_te_w_out, c_te_e_out;
   logic [CW-1:0] c_bit_count;
   logic          c_frame_done, c_frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 prog_clk = ~prog_clk;

   cfg_chain_feedthrough #(
      .NUM_CHAINS (NC),
      .PIPE_DEPTH (2),
      .FRAME_LEN  (FL),
      .RETIME_CTRL(1'b1)
   ) dut (
      .prog_clk          (prog_clk),
      .pReset_N          (pReset_N),
      .config_enable_N_in(en_in),
      .config_enable     (cfg_en),
      .sc_head_N_in      (sc_in),
      .sc_head_S_out     (sc_out),
      .reset_E_in        (rst_e_in),
      .reset_W_in        (rst_w_in),
      .reset_W_out       (rst_w_out),
      .reset_E_out       (rst_e_out),
      .Test_en_E_in      (te_e_in),
      .Test_en_W_in      (te_w_in),
      .Test_en_W_out     (te_w_out),
      .Test_en_E_out     (te_e_out),
      .bit_count         (bit_count),
      .frame_done        (frame_done),
      .frame_err         (frame_err)
   );

   cfg_chain_feedthrough #(
      .NUM_CHAINS (NC),
      .PIPE_DEPTH (0),
      .FRAME_LEN  (FL),
      .RETIME_CTRL(1'b0)
   ) dut_comb (
      .prog_clk          (prog_clk),
      .pReset_N          (pReset_N),
      .config_enable_N_in(en_in),
      .config_enable     (c_cfg_en),
      .sc_head_N_in      (sc_in),
      .sc_head_S_out     (c_sc_out),
      .reset_E_in        (rst_e_in),
      .reset_W_in        (rst_w_in),
      .reset_W_out       (c_rst_w_out),
      .reset_E_out       (c_rst_e_out),
      .Test_en_E_in      (te_e_in),
      .Test_en_W_in      (te_w_in),
      .Test_en_W_out     (c_te_w_out),
      .Test_en_E_out     (c_te_e_out),
      .bit_count         (c_bit_count),
      .frame_done        (c_frame_done),
      .frame_err         (c_frame_err)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge prog_clk);
      #1;
   endtask

   // Check the frame tracker of the registered instance.
   task automatic check_frame(input string tag, input int cnt, input bit done, input bit err);
      check_val({tag, " bit_count"}, 32'(bit_count), 32'(cnt));
      check_val({tag, " frame_done"}, 32'(frame_done), 32'(done));
      check_val({tag, " frame_err"}, 32'(frame_err), 32'(err));
   endtask

   initial begin
      // Reset with inputs toggling
      pReset_N = 1'b0;
      en_in    = 1'b1;
      sc_in    = 2'b11;
      rst_e_in = 1'b1; rst_w_in = 1'b1; te_e_in = 1'b1; te_w_in = 1'b1;
      step();
      sc_in    = 2'b10;
      rst_e_in = 1'b0; te_w_in = 1'b0;
      step();
      check_val("rst config_enable", 32'(cfg_en), 32'd0);
      check_val("rst sc_out", 32'(sc_out), 32'd0);
      check_val("rst reset_W_out", 32'(rst_w_out), 32'd0);
      check_val("rst reset_E_out", 32'(rst_e_out), 32'd0);
      check_val("rst Test_en_W_out", 32'(te_w_out), 32'd0);
      check_val("rst Test_en_E_out", 32'(te_e_out), 32'd0);
      check_frame("rst", 0, 1'b0, 1'b0);

      // Release with enable low: nothing moves
      en_in = 1'b0; sc_in = 2'b11;
      rst_e_in = 1'b0; rst_w_in = 1'b0; te_e_in = 1'b0; te_w_in = 1'b0;
      pReset_N = 1'b1;
      step();
      step();
      check_val("idle sc_out", 32'(sc_out), 32'd0);
      check_val("idle config_enable", 32'(cfg_en), 32'd0);
      check_frame("idle", 0, 1'b0, 1'b0);

      // Nominal frame: enable registers first, then 4 shift edges
      en_in = 1'b1;
      step();
      check_val("nom config_enable", 32'(cfg_en), 32'd1);
      check_val("nom pre bit_count", 32'(bit_count), 32'd0);
      sc_in = 2'b01; step();
      check_val("nom s1 sc_out", 32'(sc_out), 32'd0);
      check_val("nom s1 bit_count", 32'(bit_count), 32'd1);
      sc_in = 2'b10; step();
      check_val("nom s2 sc_out", 32'(sc_out), 32'b01);
      check_val("nom s2 bit_count", 32'(bit_count), 32'd2);
      sc_in = 2'b11; step();
      check_val("nom s3 sc_out", 32'(sc_out), 32'b10);
      check_val("nom s3 bit_count", 32'(bit_count), 32'd3);
      sc_in = 2'b00; en_in = 1'b0; step();
      check_val("nom s4 sc_out", 32'(sc_out), 32'b11);
      check_frame("nom s4", 4, 1'b1, 1'b0);
      step();
      check_val("nom after sc_out", 32'(sc_out), 32'b11);
      check_frame("nom after", 0, 1'b1, 1'b0);

      // Short frame: two shifts then enable drops
      en_in = 1'b1; step();
      sc_in = 2'b01; step();
      check_val("short s1 sc_out", 32'(sc_out), 32'b00);
      check_frame("short s1", 1, 1'b0, 1'b0);
      sc_in = 2'b10; en_in = 1'b0; step();
      check_val("short s2 sc_out", 32'(sc_out), 32'b01);
      check_val("short s2 bit_count", 32'(bit_count), 32'd2);
      sc_in = 2'b11; step();
      check_val("short end sc_out", 32'(sc_out), 32'b01);
      check_frame("short end", 0, 1'b0, 1'b1);
      step();
      check_val("short hold sc_out", 32'(sc_out), 32'b01);

      // Good frame after the error: frame_err stays sticky
      en_in = 1'b1; step();
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) en_in = 1'b0;
         step();
      end
      check_frame("good", 4, 1'b1, 1'b1);
      step();
      check_frame("good after", 0, 1'b1, 1'b1);

      // Overrun: clear the sticky error, then hold enable for 6 shift edges
      pReset_N = 1'b0; step();
      pReset_N = 1'b1; en_in = 1'b1; step();
      check_frame("ovr pre", 0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step();
      check_frame("ovr s3", 3, 1'b0, 1'b0);
      step();
      check_frame("ovr s4", 4, 1'b1, 1'b0);
      en_in = 1'b1; step();
      check_frame("ovr s5", 4, 1'b1, 1'b1);
      en_in = 1'b0; step();
      check_frame("ovr s6", 4, 1'b1, 1'b1);
      step();
      check_frame("ovr end", 0, 1'b1, 1'b1);

      // Control retiming: registered vs combinational forwarding
      rst_e_in = 1'b1; #1;
      check_val("rt reset_W_out pre", 32'(rst_w_out), 32'd0);
      check_val("comb reset_W_out", 32'(c_rst_w_out), 32'd1);
      step();
      check_val("rt reset_W_out", 32'(rst_w_out), 32'd1);
      rst_e_in = 1'b0; #1;
      check_val("comb reset_W_out low", 32'(c_rst_w_out), 32'd0);
      step();
      check_val("rt reset_W_out low", 32'(rst_w_out), 32'd0);
      te_w_in = 1'b1; #1;
      check_val("rt Test_en_E_out pre", 32'(te_e_out), 32'd0);
      check_val("comb Test_en_E_out", 32'(c_te_e_out), 32'd1);
      check_val("rt Test_en_W_out iso", 32'(te_w_out), 32'd0);
      step();
      check_val("rt Test_en_E_out", 32'(te_e_out), 32'd1);
      te_w_in = 1'b0;
      rst_w_in = 1'b1; te_e_in = 1'b1; step();
      check_val("rt Test_en_E_out low", 32'(te_e_out), 32'd0);
      check_val("rt reset_E_out", 32'(rst_e_out), 32'd1);
      check_val("rt Test_en_W_out", 32'(te_w_out), 32'd1);
      check_val("comb reset_E_out", 32'(c_rst_e_out), 32'd1);
      check_val("comb Test_en_W_out", 32'(c_te_w_out), 32'd1);
      rst_w_in = 1'b0; te_e_in = 1'b0;

      // Zero-depth pipe passes chain heads straight through
      sc_in = 2'b10; #1;
      check_val("comb sc_out 10", 32'(c_sc_out), 32'b10);
      sc_in = 2'b01; #1;
      check_val("comb sc_out 01", 32'(c_sc_out), 32'b01);

      // Mid-frame reset at bit_count=2
      en_in = 1'b1; step();
      sc_in = 2'b11; step();
      step();
      check_val("mid bit_count", 32'(bit_count), 32'd2);
      check_val("mid sc_out", 32'(sc_out), 32'b11);
      pReset_N = 1'b0; step();
      check_val("mid rst sc_out", 32'(sc_out), 32'd0);
      check_val("mid rst config_enable", 32'(cfg_en), 32'd0);
      check_frame("mid rst", 0, 1'b0, 1'b0);
      pReset_N = 1'b1; en_in = 1'b0; step();
      step();
      check_frame("mid after", 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
